dff_en_areset_n: RTL and testbench



---
 rtl/dff_en_areset_n.sv | 34 +++
 tb/tb_dff_en_areset_n.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/dff_en_areset_n.sv
// Multi-bit register with load enable and asynchronous active-low reset to a constant.
// The output comes straight from the flops, with no combinational path from data_i or en_i.
module dff_en_areset_n #(
  parameter int width_p     = 1,
  parameter     reset_val_p = 0
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  // A reset constant wider than the register keeps only its low width_p bits.
  localparam logic [width_p-1:0] reset_val_lp = width_p'(reset_val_p);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      data_o <= reset_val_lp;
    end else if (en_i) begin
      data_o <= data_i;
    end
  end

`ifndef SYNTHESIS
  if (width_p < 1) begin : g_bad_width
    $error("dff_en_areset_n: width_p must be >= 1 (got %0d)", width_p);
  end

  en_known_a: assert property (@(posedge clk_i) disable iff (!reset_n_i) !$isunknown(en_i))
    else $error("dff_en_areset_n: en_i is X/Z at a clock edge outside reset");
`endif

endmodule

// File: tb/tb_dff_en_areset_n.sv
// Scoreboard bench for dff_en_areset_n: three instances (34-bit/0, 8-bit/A5, 4-bit with a wide reset constant).
// Stimulus queues expected outputs; a negedge monitor pops and compares them.
module tb_dff_en_areset_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, en_a;
  logic [33:0] din_a, dout_a;
  logic        rst_b, en_b;
  logic [7:0]  din_b, dout_b;
  logic        rst_c, en_c;
  logic [3:0]  din_c, dout_c;

  dff_en_areset_n #(.width_p(34), .reset_val_p(0)) dut_a (
    .clk_i(clk), .reset_n_i(rst_a), .en_i(en_a), .data_i(din_a), .data_o(dout_a)
  );

  dff_en_areset_n #(.width_p(8), .reset_val_p(8'hA5)) dut_b (
    .clk_i(clk), .reset_n_i(rst_b), .en_i(en_b), .data_i(din_b), .data_o(dout_b)
  );

  // 12'h1F5 truncated to 4 bits gives 4'h5.
  dff_en_areset_n #(.width_p(4), .reset_val_p(12'h1F5)) dut_c (
    .clk_i(clk), .reset_n_i(rst_c), .en_i(en_c), .data_i(din_c), .data_o(dout_c)
  );

  typedef struct {
    int unsigned sel;
    logic [33:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int compared   = 0;
  int mismatched = 0;

  task automatic push(input int unsigned sel, input logic [33:0] exp, input string name);
    exp_t e;
    e.sel  = sel;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  // Returns 2 ns after a rising edge; inputs set here are sampled at the following edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        exp_t        e;
        logic [33:0] act;
        e = sb.pop_front();
        case (e.sel)
          0:       act = dout_a;
          1:       act = {26'b0, dout_b};
          default: act = {30'b0, dout_c};
        endcase
        compared++;
        if (act !== e.exp) begin
          mismatched++;
          $display("FAIL %s: got %h expected %h (t=%0t)", e.name, act, e.exp, $time);
        end
      end
    end
  end

  initial begin : stimulus
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    en_a  = 1'b1; din_a = '1;
    en_b  = 1'b1; din_b = 8'hFF;
    en_c  = 1'b1; din_c = 4'hF;
    #1;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    // Reset held with enable high and all-ones data
    repeat (3) begin
      tick();
      push(0, 34'h0,  "a_rst_hold");
      push(1, 34'hA5, "b_rst_prio");
      push(2, 34'h5,  "c_rst_trunc");
    end

    en_b  = 1'bx;
    din_b = 'x;
    tick();
    push(0, 34'h0,  "a_rst_hold");
    push(1, 34'hA5, "b_x_in_rst");

    // Release: a and c load at the first edge, b releases without enable
    rst_a = 1'b1; en_a = 1'b1; din_a = 34'h2_DEAD_BEEF;
    rst_b = 1'b1; en_b = 1'b0; din_b = 8'hFF;
    rst_c = 1'b1; en_c = 1'b1; din_c = 4'hA;
    tick();
    push(0, 34'h2_DEAD_BEEF, "a_load");
    push(1, 34'hA5,          "b_rel_noen");
    push(2, 34'hA,           "c_load");

    en_a = 1'b0; din_a = 34'h1_1234_5678;
    en_b = 1'b1; din_b = 8'h3C;
    en_c = 1'b0; din_c = 4'h3;
    tick();
    push(0, 34'h2_DEAD_BEEF, "a_hold");
    push(1, 34'h3C,          "b_load");
    push(2, 34'hA,           "c_hold");

    en_b = 1'b0; din_b = 8'h00;
    for (int i = 1; i <= 4; i++) begin
      en_a  = 1'b1;
      din_a = 34'(i);
      tick();
      push(0, 34'(i), "a_stream");
    end
    push(1, 34'h3C, "b_hold");

    din_a = 34'h0_CAFE_F00D;
    tick();
    push(0, 34'h0_CAFE_F00D, "a_load2");

    // Reset dropped 3 ns after an edge must clear before the next edge
    en_a = 1'b0; din_a = 34'h3_FFFF_FFFF;
    tick();
    #1;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    push(0, 34'h0,  "a_async_rst");
    push(1, 34'hA5, "b_async_rst");
    push(2, 34'h5,  "c_async_rst");

    en_a = 1'b1; en_b = 1'b1; din_b = 8'h77; en_c = 1'b1; din_c = 4'hE;
    tick();
    push(0, 34'h0,  "a_rst_held");
    push(1, 34'hA5, "b_rst_held");
    push(2, 34'h5,  "c_rst_held");

    @(negedge clk);
    #1;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    din_a = 34'h1_5555_AAAA;
    repeat (2) begin
      tick();
      push(0, 34'h0,  "a_post_rst");
      push(1, 34'hA5, "b_post_rst");
      push(2, 34'h5,  "c_post_rst");
    end

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
      mismatched += sb.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
